// File: rtl/bbox_rasterizer_if.sv
// Triangle-in / pixel-point-out bus of the bounding-box rasterizer.
// The slave side is the rasterizer; the master side is the feeder/consumer pair.
interface bbox_rasterizer_if;
  logic                  valid_in;
  logic                  ready_out;
  logic [2:0][1:0][16:0] vertices_in;
  logic                  hold_in;
  logic                  valid_out;
  logic [1:0][16:0]      point_out;
  logic [2:0][1:0][16:0] vertices_out;
  logic                  last_out;

  modport master (
    output valid_in, vertices_in, hold_in,
    input  ready_out, valid_out, point_out, vertices_out, last_out
  );

  modport slave (
    input  valid_in, vertices_in, hold_in,
    output ready_out, valid_out, point_out, vertices_out, last_out
  );
endinterface

// File: rtl/bbox_rasterizer.sv
// Accepts one triangle, computes its screen-clipped bounding box and walks
// every pixel of that box in row-major order, tagging each with the triangle.
module bbox_rasterizer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input logic              clk_in,
  input logic              rst_in,
  bbox_rasterizer_if.slave bus
);

  localparam logic signed [16:0] XLIM = 17'(WIDTH - 1);
  localparam logic signed [16:0] YLIM = 17'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, BOUND, CLIP, SCAN} state_t;

  state_t state, state_nxt;

  logic [2:0][1:0][16:0] vert_q;
  logic signed [16:0]    v0x, v0y, v1x, v1y, v2x, v2y;
  logic signed [16:0]    bxmin_p0, bxmax_p0, bymin_p0, bymax_p0;
  logic signed [16:0]    clip_xmin, clip_xmax, clip_ymin, clip_ymax;
  logic signed [16:0]    cxmin_p1, cxmax_p1, cymax_p1;
  logic signed [16:0]    x_q, y_q;
  logic                  box_empty, accept, emit, at_last;
  logic                  vld_p2, last_p2;
  logic [1:0][16:0]      point_p2;

  function automatic logic signed [16:0] smin(input logic signed [16:0] a,
                                              input logic signed [16:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [16:0] smax(input logic signed [16:0] a,
                                              input logic signed [16:0] b);
    return (a > b) ? a : b;
  endfunction

  assign v0x = $signed(vert_q[0][0]);
  assign v0y = $signed(vert_q[0][1]);
  assign v1x = $signed(vert_q[1][0]);
  assign v1y = $signed(vert_q[1][1]);
  assign v2x = $signed(vert_q[2][0]);
  assign v2y = $signed(vert_q[2][1]);

  assign bus.ready_out = (state == IDLE) && rst_in;
  assign accept        = bus.valid_in && bus.ready_out;
  assign emit          = (state == SCAN) && !bus.hold_in;
  assign at_last       = (x_q == cxmax_p1) && (y_q == cymax_p1);

  assign clip_xmin = smax(bxmin_p0, 17'sd0);
  assign clip_xmax = smin(bxmax_p0, XLIM);
  assign clip_ymin = smax(bymin_p0, 17'sd0);
  assign clip_ymax = smin(bymax_p0, YLIM);
  assign box_empty = (clip_xmin > clip_xmax) || (clip_ymin > clip_ymax);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BOUND;
      BOUND:   state_nxt = CLIP;
      CLIP:    state_nxt = box_empty ? IDLE : SCAN;
      SCAN:    if (emit && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: raw bounding box of the captured triangle
  always_ff @(posedge clk_in) begin
    if (state == BOUND) begin
      bxmin_p0 <= smin(smin(v0x, v1x), v2x);
      bxmax_p0 <= smax(smax(v0x, v1x), v2x);
      bymin_p0 <= smin(smin(v0y, v1y), v2y);
      bymax_p0 <= smax(smax(v0y, v1y), v2y);
    end
  end

  // Stage p1: clipped box and the row-major scan counters
  always_ff @(posedge clk_in) begin
    if (state == CLIP) begin
      cxmin_p1 <= clip_xmin;
      cxmax_p1 <= clip_xmax;
      cymax_p1 <= clip_ymax;
      x_q      <= clip_xmin;
      y_q      <= clip_ymin;
    end else if (emit) begin
      if (x_q < cxmax_p1) begin
        x_q <= x_q + 17'sd1;
      end else begin
        x_q <= cxmin_p1;
        y_q <= y_q + 17'sd1;
      end
    end
  end

  // Stage p2: registered point stream; a held cycle keeps the last point
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      point_p2 <= '0;
      vert_q   <= '0;
    end else begin
      vld_p2  <= emit;
      last_p2 <= emit && at_last;
      if (emit)   point_p2 <= {y_q, x_q};
      if (accept) vert_q   <= bus.vertices_in;
    end
  end

  assign bus.valid_out    = vld_p2;
  assign bus.last_out     = last_p2;
  assign bus.point_out    = point_p2;
  assign bus.vertices_out = vert_q;

endmodule
